// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, req/ack instruction memory port, one-entry IF/ID buffer.
// Squash drops the in-flight response when a branch lands during WAIT.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4,
  parameter logic [31:0] NOP_INST = 32'hE000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic [31:0] instructionOut,
  output logic [31:0] pcOut,
  output logic        fetchValid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_buf_valid;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc;
  logic        r_squash;

  logic        w_consume;
  logic        w_can_issue;
  logic        w_req;
  logic        w_ack;
  logic [31:0] w_addr;
  logic [31:0] w_pc_next;

  assign w_consume   = r_buf_valid & ~freeze;
  assign w_can_issue = (~r_buf_valid | w_consume) & ~branchTaken;
  assign w_req       = ~rst & ((r_state == S_WAIT) |
                               ((r_state == S_IDLE) & w_can_issue));
  assign w_ack       = w_req & memAck;

  // The outstanding request keeps its address even if pc is redirected.
  assign w_addr    = (r_state == S_WAIT) ? r_req_addr : r_pc;
  assign w_pc_next = w_addr + STEP;

  assign memReq         = w_req;
  assign memAddr        = w_addr;
  assign instructionOut = r_buf_valid ? r_buf_inst : NOP_INST;
  assign pcOut          = r_buf_pc;
  assign fetchValid     = r_buf_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_buf_valid <= 1'b0;
      r_buf_inst  <= NOP_INST;
      r_buf_pc    <= 32'h0;
      r_squash    <= 1'b0;
    end else if (w_ack) begin
      r_state <= S_IDLE;
      if (branchTaken) begin
        r_pc        <= branchAddr;
        r_squash    <= 1'b0;
        r_buf_valid <= 1'b0;
      end else if (r_squash) begin
        r_squash <= 1'b0;
      end else begin
        r_buf_inst  <= memData;
        r_buf_pc    <= w_pc_next;
        r_pc        <= w_pc_next;
        r_buf_valid <= 1'b1;
      end
    end else if (r_state == S_WAIT) begin
      if (branchTaken) begin
        r_pc     <= branchAddr;
        r_squash <= 1'b1;
      end
    end else if (branchTaken) begin
      r_pc        <= branchAddr;
      r_buf_valid <= 1'b0;
    end else begin
      if (w_req) begin
        r_state    <= S_WAIT;
        r_req_addr <= r_pc;
      end
      if (w_consume) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: latency-programmable memory, directed
// scenarios and a random phase checked against an address-stream model.
module tb_inst_fetch_unit;

  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branchTaken;
  logic [31:0] branchAddr;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic [31:0] instructionOut;
  logic [31:0] pcOut;
  logic        fetchValid;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat     = 0;
  int   wait_cnt;
  logic force_ack = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .branchTaken   (branchTaken),
    .branchAddr    (branchAddr),
    .memReq        (memReq),
    .memAddr       (memAddr),
    .memAck        (memAck),
    .memData       (memData),
    .instructionOut(instructionOut),
    .pcOut         (pcOut),
    .fetchValid    (fetchValid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hE100_0000;
  endfunction

  // Memory acks once a request has been waiting `lat` cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (memReq && !memAck) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always_comb begin
    memAck  = force_ack || (memReq && wait_cnt >= lat);
    memData = mem_word(memAddr);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: delivered instructions form the address stream that
  // starts at 0, advances by 4 per consumed fetch, restarts at a branch.
  logic [31:0] exp_addr;
  logic        prev_pend;
  logic [31:0] prev_addr;
  int          delivered = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp_addr  <= 32'h0;
      prev_pend <= 1'b0;
      prev_addr <= 32'h0;
    end else begin
      if (prev_pend) begin
        chk("req_hold", 32'(memReq), 32'd1);
        chk("addr_hold", memAddr, prev_addr);
      end
      if (fetchValid) begin
        chk("m_pc", pcOut, exp_addr + 32'd4);
        chk("m_inst", instructionOut, mem_word(exp_addr));
        delivered <= delivered + 1;
      end else begin
        chk("m_nop", instructionOut, NOP);
      end
      prev_pend <= memReq && !memAck;
      prev_addr <= memAddr;
      if (branchTaken) exp_addr <= branchAddr;
      else if (fetchValid && !freeze) exp_addr <= exp_addr + 32'd4;
    end
  end

  task automatic wait_fv(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!fetchValid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(fetchValid), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int          pulses;
    int          reqs;
    int          n;
    int          d0;

    rst         = 1'b1;
    freeze      = 1'b0;
    branchTaken = 1'b0;
    branchAddr  = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(memReq), 32'd0);
    chk("rst_inst", instructionOut, NOP);
    chk("rst_pc", pcOut, 32'h0);
    chk("rst_fv", 32'(fetchValid), 32'd0);
    chk("rst_addr", memAddr, 32'h0);

    @(posedge clk); #1 rst = 1'b0;

    // zero-wait memory streams one instruction per cycle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("zw_req", 32'(memReq), 32'd1);
      chk("zw_addr", memAddr, 32'(4 * k));
      chk("zw_fv", 32'(fetchValid), (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) chk("zw_pc", pcOut, 32'(4 * k));
    end

    @(posedge clk); #1 freeze = 1'b1;
    held = pcOut;
    repeat (5) begin
      @(negedge clk);
      chk("frz_req", 32'(memReq), 32'd0);
      chk("frz_pc", pcOut, held);
      chk("frz_fv", 32'(fetchValid), 32'd1);
    end
    @(posedge clk); #1 freeze = 1'b0;
    @(negedge clk);
    chk("unfrz_req", 32'(memReq), 32'd1);
    chk("unfrz_addr", memAddr, held);

    @(posedge clk); #1 lat = 3;
    wait_fv("lat_sync");
    pulses = 0;
    reqs   = 0;
    repeat (16) begin
      @(negedge clk);
      pulses += 32'(fetchValid);
      reqs   += 32'(memReq);
    end
    chk("lat_pulses", 32'(pulses), 32'd4);
    chk("lat_reqs", 32'(reqs), 32'd16);

    // branch while waiting: in-flight response must be dropped
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(memReq && !memAck && wait_cnt == 1) && n < 40);
    chk("seek_wait", 32'(n < 40), 32'd1);
    branchTaken = 1'b1;
    branchAddr  = 32'h100;
    @(posedge clk); #1 branchTaken = 1'b0;
    wait_fv("brw_fv");
    chk("brw_pc", pcOut, 32'h104);
    chk("brw_inst", instructionOut, mem_word(32'h100));

    // branch coinciding with ack: no squash left behind
    @(posedge clk); #1 lat = 2;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(memReq && memAck && wait_cnt >= 2) && n < 40);
    chk("seek_ack", 32'(n < 40), 32'd1);
    branchTaken = 1'b1;
    branchAddr  = 32'h200;
    @(posedge clk); #1 branchTaken = 1'b0;
    n = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!fetchValid && n < 40);
    chk("bra_lat", 32'(n), 32'd5);
    chk("bra_pc", pcOut, 32'h204);

    // asynchronous reset in the middle of a request
    @(posedge clk); #1 lat = 3;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(memReq && !memAck) && n < 40);
    chk("seek_rst", 32'(n < 40), 32'd1);
    #2 rst = 1'b1;
    force_ack = 1'b1;
    #1;
    chk("arst_req", 32'(memReq), 32'd0);
    chk("arst_addr", memAddr, 32'h0);
    chk("arst_fv", 32'(fetchValid), 32'd0);
    @(negedge clk);
    chk("arst_fv2", 32'(fetchValid), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    force_ack = 1'b0;
    wait_fv("arst_restart");
    chk("arst_pc", pcOut, 32'h4);

    // random phase checked by the stream model
    d0 = delivered;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (i % 100 == 0) lat = int'($urandom_range(0, 2));
      freeze      = ($urandom % 4) == 0;
      branchTaken = ($urandom % 12) == 0;
      branchAddr  = (($urandom % 8) == 0) ? 32'hFFFF_FFF8
                                          : ($urandom & 32'h0000_FFFC);
    end
    @(posedge clk); #1;
    branchTaken = 1'b0;
    freeze      = 1'b0;
    @(negedge clk);
    chk("rand_deliv", 32'((delivered - d0) > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
